// File: rtl/spike_delay_buffer.sv
// spike_delay_buffer: per-line programmable axonal delay ahead of a LIF neuron.
// Each of M spike lines is re-timed by its own delay of 0..2^Nbits-1 enabled
// steps using an independent history shift register tapped at dly-1.
// Optional macro SPIKE_DELAY_COUNT_EN builds a saturating delivered-spike
// counter; when undefined, spike_count is tied to zero.
module spike_delay_buffer #(
  parameter int M     = 8,
  parameter int Nbits = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [M-1:0]         input_spikes,
  input  logic [M*Nbits-1:0]   delays,
  input  logic                 load_delays,
  input  logic                 flush,
  output logic [M-1:0]         delayed_spikes,
  output logic                 pending,
  output logic [15:0]          spike_count
);

  localparam int D  = 2 ** Nbits;
  localparam int HW = D - 1;

  logic [Nbits-1:0] dly  [M];
  logic [HW-1:0]    hist [M];
  logic [M-1:0]     tap;
  logic             pend_any;

  // Delay registers: captured on load, independent of enable and flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < M; i++) dly[i] <= '0;
    end else if (load_delays) begin
      for (int unsigned i = 0; i < M; i++) dly[i] <= delays[i*Nbits +: Nbits];
    end
  end

  // Tap select: delay 0 passes the live input, otherwise the history entry dly-1.
  always_comb begin
    tap = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (dly[i] == '0) tap[i] = input_spikes[i];
      else              tap[i] = hist[i][dly[i] - Nbits'(1)];
    end
  end

  // Pending: any history bit still ahead of its line's tap will be delivered.
  always_comb begin
    pend_any = 1'b0;
    for (int unsigned i = 0; i < M; i++) begin
      for (int unsigned k = 0; k < HW; k++) begin
        if (k < 32'(dly[i])) pend_any = pend_any | hist[i][k];
      end
    end
  end

  assign pending = pend_any;

  // History shift and registered output; flush wins over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < M; i++) hist[i] <= '0;
      delayed_spikes <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < M; i++) hist[i] <= '0;
      delayed_spikes <= '0;
    end else if (enable) begin
      for (int unsigned i = 0; i < M; i++) hist[i] <= (hist[i] << 1) | HW'(input_spikes[i]);
      delayed_spikes <= tap;
    end
  end

`ifdef SPIKE_DELAY_COUNT_EN
  localparam int PCW = $clog2(M + 1);

  logic [PCW-1:0] popcnt;
  logic [16:0]    sum;
  logic [15:0]    count;

  // Popcount of the spikes being registered on this edge.
  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < M; i++) popcnt = popcnt + PCW'(tap[i]);
  end

  assign sum = {1'b0, count} + 17'(popcnt);

  // Saturating delivered-spike counter, cleared by reset and flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (enable) begin
      count <= sum[16] ? '1 : sum[15:0];
    end
  end

  assign spike_count = count;
`else
  assign spike_count = '0;
`endif

endmodule

// File: tb/tb_spike_delay_buffer.sv
// Self-checking bench for spike_delay_buffer: vector table plus hand-written
// multi-cycle sequences; expectations are queued when stimulus is driven and
// compared after the clock edge that produces them.
module tb_spike_delay_buffer;

`ifdef SPIKE_DELAY_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  input_spikes;
  logic [15:0] delays;
  logic        load_delays;
  logic        flush;
  logic [7:0]  delayed_spikes;
  logic        pending;
  logic [15:0] spike_count;

  spike_delay_buffer #(.M(8), .Nbits(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .input_spikes   (input_spikes),
    .delays         (delays),
    .load_delays    (load_delays),
    .flush          (flush),
    .delayed_spikes (delayed_spikes),
    .pending        (pending),
    .spike_count    (spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] spk;
    logic       pend;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    string      name;
    bit         en;
    bit [7:0]   in;
    bit         ld;
    bit [15:0]  dl;
    bit         fl;
    bit [7:0]   e_spk;
    bit         e_pend;
  } vec_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_cnt = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one clock of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string name, input bit en, input bit [7:0] in, input bit ld,
                      input bit [15:0] dl, input bit fl, input bit [7:0] e_spk, input bit e_pend);
    exp_t e;
    exp_t got;
    enable = en; input_spikes = in; load_delays = ld; delays = dl; flush = fl;
    if (fl) exp_cnt = 0;
    else if (en) begin
      exp_cnt = exp_cnt + $countones(e_spk);
      if (exp_cnt > 16'hFFFF) exp_cnt = 16'hFFFF;
    end
    e.name = name; e.spk = e_spk; e.pend = e_pend;
    e.cnt = CNT_EN ? 16'(exp_cnt) : 16'h0000;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      got = sb.pop_front();
      check({got.name, "_spk"},  {8'h00, delayed_spikes}, {8'h00, got.spk});
      check({got.name, "_pend"}, {15'h0, pending},        {15'h0, got.pend});
      check({got.name, "_cnt"},  spike_count,             got.cnt);
    end
  endtask

  vec_t tbl[6];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // line0=0, line1=1, line2=2, line3=3, others 0 -> 16'h00E4
    tbl[0] = '{"load_e4",  1'b1, 8'h00, 1'b1, 16'h00E4, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{"pulse_k",  1'b1, 8'h0F, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b1};
    tbl[2] = '{"k_plus1",  1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1};
    tbl[3] = '{"k_plus2",  1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h04, 1'b1};
    tbl[4] = '{"k_plus3",  1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h08, 1'b0};
    tbl[5] = '{"k_plus4",  1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0};

    // Reset defaults with random inputs held for 3 clocks
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      enable = 1'($urandom); input_spikes = 8'($urandom); load_delays = 1'($urandom);
      delays = 16'($urandom); flush = 1'($urandom);
      @(posedge clk); #1;
    end
    enable = 1'b0; input_spikes = 8'h00; load_delays = 1'b0; delays = 16'h0000; flush = 1'b0;
    reset = 1'b1;
    exp_cnt = 0;
    check("rst_spk",  {8'h00, delayed_spikes}, 16'h0000);
    check("rst_pend", {15'h0, pending},        16'h0000);
    check("rst_cnt",  spike_count,             16'h0000);
    step("rst_d0",   1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0);
    step("rst_d0b",  1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Per-line delays from the vector table
    for (int v = 0; v < 6; v++)
      step(tbl[v].name, tbl[v].en, tbl[v].in, tbl[v].ld, tbl[v].dl, tbl[v].fl,
           tbl[v].e_spk, tbl[v].e_pend);

    // Enable gaps: line0 delay 3, 5 idle clocks after each enabled edge
    step("gap_load",   1'b0, 8'h00, 1'b1, 16'h0003, 1'b0, 8'h00, 1'b0);
    step("gap_inject", 1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      for (int g = 0; g < 5; g++)
        step("gap_hold", 1'b0, 8'hFF, 1'b0, 16'h0000, 1'b0, (e == 1) ? 8'h00 : ((e == 4) ? 8'h01 : 8'h00), 1'b1);
      step("gap_edge", 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, (e == 3) ? 8'h01 : 8'h00, (e == 3) ? 1'b0 : 1'b1);
    end
    for (int g = 0; g < 5; g++)
      step("gap_hold_out", 1'b0, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0);
    step("gap_clear", 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Mid-flight reload to 0 drops the spike
    step("rl0_inject", 1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    step("rl0_load",   1'b1, 8'h00, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 3; s++)
      step("rl0_drop", 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Mid-flight reload to 2 delivers one step after the reload edge
    step("rl2_pre",    1'b0, 8'h00, 1'b1, 16'h0003, 1'b0, 8'h00, 1'b0);
    step("rl2_inject", 1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    step("rl2_load",   1'b1, 8'h00, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b1);
    step("rl2_out",    1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0);
    step("rl2_after",  1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    // Flush with enable: all lines delay 1
    step("fl_load",  1'b0, 8'h00, 1'b1, 16'h5555, 1'b0, 8'h00, 1'b0);
    step("fl_in1",   1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    step("fl_in2",   1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b1);
    step("fl_flush", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0);
    step("fl_keep1", 1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    step("fl_keep2", 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h01, 1'b0);

    // Async reset mid-cycle
    step("ar_in1", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
    step("ar_in2", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("ar_spk",  {8'h00, delayed_spikes}, 16'h0000);
    check("ar_pend", {15'h0, pending},        16'h0000);
    check("ar_cnt",  spike_count,             16'h0000);
    exp_cnt = 0;
    #2 reset = 1'b1;
    step("ar_d0", 1'b1, 8'h80, 1'b0, 16'h0000, 1'b0, 8'h80, 1'b0);

    // Counter: flush, then 10 edges of 8'hFF at delay 0 -> 80
    step("cnt_flush", 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0);
    for (int s = 0; s < 10; s++)
      step("cnt_ff", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0);
    check("cnt_80", spike_count, CNT_EN ? 16'd80 : 16'd0);
    for (int s = 10; s < 8191; s++)
      step("cnt_run", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0);
    check("cnt_65528", spike_count, CNT_EN ? 16'd65528 : 16'd0);
    step("cnt_sat1", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0);
    check("cnt_sat", spike_count, CNT_EN ? 16'hFFFF : 16'h0000);
    step("cnt_sat2", 1'b1, 8'hFF, 1'b0, 16'h0000, 1'b0, 8'hFF, 1'b0);
    check("cnt_hold_sat", spike_count, CNT_EN ? 16'hFFFF : 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_delay_buffer.md
# spike_delay_buffer

- Programmable per-synapse axonal delay stage that sits directly upstream of the LIF neuron.
- Takes M raw presynaptic spike lines and re-times each one by its own configured delay of 0 to 2^Nbits−1 time steps.
- Presents the re-timed vector as the neuron's `input_spikes`.
- A time step is one clock edge with `enable` high, so the block advances in lockstep with the neuron it feeds.

## Interface
- `M`, 8, number of spike lines (matches neuron M).
- `Nbits`, 2, delay field width per line; max delay 2^Nbits−1 steps.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `enable` input 1: time-step advance, shared with downstream neuron.
- `input_spikes` input M: raw presynaptic spikes, sampled on enabled edges.
- `delays` input M*Nbits: line i delay in bits [i*Nbits +: Nbits].
- `load_delays` input 1: capture `delays` into internal delay registers.
- `flush` input 1: synchronous clear of all in-flight spikes.
- `delayed_spikes` output M: re-timed spikes, registered, to neuron `input_spikes`.
- `pending` output 1: high while any in-flight spike will still be delivered under current delays.
- `spike_count` output 16: saturating count of delivered spikes (see Configuration).

## Operation
- **Per-line history.** Each line i has a history shift register of depth D−1, where D = 2^Nbits.
  - h_i[0] is the newest sample.
- **Delay register.** Each line has a delay register dly_i of Nbits bits.
- **Enabled edge** (`enable`=1, `flush`=0):
  - delayed_spikes[i] <= (dly_i==0) ? input_spikes[i] : h_i[dly_i−1]. Both operands are pre-edge values.
  - h_i shifts: h_i[0] <= input_spikes[i]; h_i[k] <= h_i[k−1].
- **`enable`=0:** history, outputs and count hold; input_spikes is ignored.
- **`load_delays`=1:** dly_i <= delays field at that edge, regardless of `enable`.
  - If load and enable coincide, the tap for that edge uses the old dly_i.
  - History is not cleared on load. A spike already in flight is delivered at whatever tap position it reaches under the new delay. It may therefore be dropped (delay shortened past it) or delivered later than originally scheduled. This is defined, accepted behaviour.
- **`flush`=1:** clears all h_i, delayed_spikes and spike_count at the edge, with priority over `enable`. Delay registers are untouched.
  - Flush and load in the same edge both take effect.
- **`pending`:** combinational from state. It is the OR over i of h_i[k] for k < dly_i; bits at or beyond the tap are unreachable and excluded.
- No arithmetic beyond tap select and the popcount adder; popcount width is clog2(M+1).

## Timing
- **Reset** (`reset`=0, async): all h_i=0, dly_i=0, delayed_spikes=0, pending=0, spike_count=0.
- **After reset** all delays are 0, so the block acts as a one-step register until loaded.
- **Latency:** a spike sampled at enabled edge k with delay d is visible on delayed_spikes after enabled edge k+d, i.e. a minimum of 1 clock.
- **Pulse width:** an output spike is one step wide; it stays asserted until the next enabled edge overwrites it.
- **Back-to-back spikes** on one line remain distinct at any delay; there is no collision because each line is an independent FIFO-free shift register.
- **Reset mid-operation:** discards all in-flight spikes immediately (async), with no partial delivery.
- **`enable` gaps:** do not count as steps; delay is measured in enabled edges, not clocks.

## Configuration
- Macro `SPIKE_DELAY_COUNT_EN`.
- **Defined:**
  - spike_count increments on each enabled edge by popcount of the newly registered delayed_spikes.
  - It saturates at 16'hFFFF and clears on reset and flush.
- **Undefined:**
  - The counter logic is not built and spike_count is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- **Reset defaults:** Hold `reset`=0 for 3 clocks with random inputs, then release. Required: delayed_spikes=0, pending=0, spike_count=0. Then with enable=1 and input_spikes=8'h01: delayed_spikes=8'h01 one clock later (delay 0).
- **Per-line delays:** Load delays with line0=0, line1=1, line2=2, line3=3, then pulse input_spikes=8'h0F for one enabled edge. Required: bit0 after edge k, bit1 after k+1, bit2 after k+2, bit3 after k+3. pending=1 through edge k+2 and 0 after k+3. Each bit is high for exactly one step.
- **Enable gaps:** With delay 3 on line0, inject a spike, then drop `enable` for 5 clocks after each enabled edge. Required: output appears only after the 3rd subsequent enabled edge, and delayed_spikes holds during gaps.
- **Mid-flight reload:** Line0 has delay 3 and a spike one step in (h_0[0]=1). Reload delay=0 at the same edge as enable. Required: the spike is dropped (never delivered) and pending goes to 0. A reload to delay 2 instead delivers it one step later.
- **Flush and async reset:** With spikes in flight on all lines, assert flush together with enable. Required: history, outputs and spike_count are 0 after the edge, and delay registers are retained. Repeat using `reset` asserted mid-cycle: outputs clear without waiting for a clock edge.
- **Counter** (`SPIKE_DELAY_COUNT_EN` defined): Drive input_spikes=8'hFF with delay 0 for 10 enabled edges. Required: spike_count=80. Preload near saturation: the count stops at 16'hFFFF. With the macro undefined, spike_count stays 0.
